// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the single-port data RAM.
// Latency: none, wires only.
// Backpressure: requesters hold req and payload until they see their one-cycle ack.
interface mem_arbiter_if #(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 8
);
  logic                      cpu_req;
  logic                      cpu_we;
  logic [MEM_ADDR_WIDTH-1:0] cpu_addr;
  logic [MEM_DATA_WIDTH-1:0] cpu_wdata;
  logic                      cpu_ack;
  logic [MEM_DATA_WIDTH-1:0] cpu_rdata;

  logic                      dma_req;
  logic                      dma_we;
  logic [MEM_ADDR_WIDTH-1:0] dma_addr;
  logic [MEM_DATA_WIDTH-1:0] dma_wdata;
  logic                      dma_ack;
  logic [MEM_DATA_WIDTH-1:0] dma_rdata;

  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_DATA_WIDTH-1:0] mem_data_o;
  logic                      mem_WE;
  logic [MEM_DATA_WIDTH-1:0] mem_data_i;

  logic                      busy;
  logic                      owner;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_data_i,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output mem_addr, mem_data_o, mem_WE, busy, owner
  );

  // Requester / memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_data_i,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  mem_addr, mem_data_o, mem_WE, busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single-port data RAM between the CPU memory stage and a DMA/debug port.
// Latency: request sampled in idle at cycle N -> one-cycle ack at N+3; grants at least 4 cycles apart.
// Backpressure: loser keeps its request pending; CPU has priority until DMA loses STARVE_LIMIT times in a row.
module mem_arbiter #(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 8,
  parameter int STARVE_LIMIT   = 4
) (
  input logic          clk,
  input logic          arst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                    state;
  logic [3:0]                starve_cnt;
  logic                      acc_we;
  logic                      any_req;
  logic                      grant_dma;
  logic                      sel_we;
  logic [MEM_ADDR_WIDTH-1:0] sel_addr;
  logic [MEM_DATA_WIDTH-1:0] sel_wdata;

  // Winner selection: CPU first, unless DMA is alone or has been starved long enough
  always_comb begin
    any_req   = bus.cpu_req | bus.dma_req;
    grant_dma = bus.dma_req & (~bus.cpu_req | (starve_cnt >= LIMIT));
    sel_we    = grant_dma ? bus.dma_we    : bus.cpu_we;
    sel_addr  = grant_dma ? bus.dma_addr  : bus.cpu_addr;
    sel_wdata = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
  end

  // Four-phase transaction sequencer; every output is registered here
  always_ff @(posedge clk) begin
    if (arst) begin
      state          <= ST_IDLE;
      starve_cnt     <= '0;
      acc_we         <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_data_o <= '0;
      bus.mem_WE     <= 1'b0;
      bus.owner      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.cpu_ack    <= 1'b0;
      bus.dma_ack    <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.dma_rdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            bus.mem_addr   <= sel_addr;
            bus.mem_data_o <= sel_wdata;
            bus.mem_WE     <= sel_we;
            acc_we         <= sel_we;
            bus.owner      <= grant_dma;
            bus.busy       <= 1'b1;
            // A CPU win only counts as a loss for DMA when DMA was actually asking
            if (grant_dma) begin
              starve_cnt <= '0;
            end else if (bus.dma_req && (starve_cnt < LIMIT)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          bus.mem_WE <= 1'b0;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          // RAM read data arrives one cycle after the address, i.e. now
          if (!acc_we) begin
            if (bus.owner) bus.dma_rdata <= bus.mem_data_i;
            else           bus.cpu_rdata <= bus.mem_data_i;
          end
          if (bus.owner) bus.dma_ack <= 1'b1;
          else           bus.cpu_ack <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          bus.cpu_ack <= 1'b0;
          bus.dma_ack <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of grants, memory contents and ack timing.
module tb_mem_arbiter;
  localparam int SL = 2;

  logic clk = 1'b0;
  logic arst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mem_arbiter_if #(.MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(8)) bus ();

  mem_arbiter #(
    .MEM_ADDR_WIDTH(8),
    .MEM_DATA_WIDTH(8),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write on mem_WE, read data valid the cycle after the address
  logic [7:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h4A;
    bus.mem_data_i = 8'h00;
    forever begin
      @(posedge clk);
      if (bus.mem_WE === 1'b1) ram[bus.mem_addr] <= bus.mem_data_o;
      bus.mem_data_i <= ram[bus.mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_cpu(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.cpu_req = r; bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic drive_dma(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.dma_req = r; bus.dma_we = w; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    drive_cpu(0, 0, 8'h00, 8'h00);
    drive_dma(0, 0, 8'h00, 8'h00);
    step();
    step();
    arst = 1'b0;
  endtask

  // Runs one CPU access to completion; lat is -1 if no ack within the budget
  task automatic cpu_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output int lat);
    lat = -1;
    rd  = 8'h00;
    drive_cpu(1, w, a, d);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.cpu_ack === 1'b1) begin
        lat = i;
        rd  = bus.cpu_rdata;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    drive_cpu(1, 0, 8'h10, 8'h77);
    step(); step(); step();
    arst = 1'b1;
    drive_cpu(0, 0, 8'h00, 8'h00);
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset.busy got %b exp 0", bus.busy); end
    checks++; if (bus.owner !== 1'b0) begin errors++; $display("FAIL reset.owner got %b exp 0", bus.owner); end
    checks++; if ({bus.cpu_ack, bus.dma_ack, bus.mem_WE} !== 3'b000) begin errors++; $display("FAIL reset.ack_we got %b exp 000", {bus.cpu_ack, bus.dma_ack, bus.mem_WE}); end
    checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL reset.mem_addr got %h exp 00", bus.mem_addr); end
    checks++; if (bus.mem_data_o !== 8'h00) begin errors++; $display("FAIL reset.mem_data_o got %h exp 00", bus.mem_data_o); end
    checks++; if ({bus.cpu_rdata, bus.dma_rdata} !== 16'h0000) begin errors++; $display("FAIL reset.rdata got %h exp 0000", {bus.cpu_rdata, bus.dma_rdata}); end
    arst = 1'b0;
  endtask

  task automatic test_cpu_read();
    bit dma_seen = 0;
    do_reset();
    drive_cpu(1, 0, 8'h10, 8'h00);
    step(); // cycle 1
    if (bus.dma_ack === 1'b1) dma_seen = 1;
    checks++; if (bus.mem_addr !== 8'h10) begin errors++; $display("FAIL cpu_read.mem_addr got %h exp 10", bus.mem_addr); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL cpu_read.busy got %b exp 1", bus.busy); end
    checks++; if (bus.mem_WE !== 1'b0) begin errors++; $display("FAIL cpu_read.mem_WE got %b exp 0", bus.mem_WE); end
    step(); // cycle 2
    if (bus.dma_ack === 1'b1) dma_seen = 1;
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_read.early_ack got %b exp 0", bus.cpu_ack); end
    step(); // cycle 3
    if (bus.dma_ack === 1'b1) dma_seen = 1;
    checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL cpu_read.ack got %b exp 1", bus.cpu_ack); end
    checks++; if (bus.cpu_rdata !== 8'h5A) begin errors++; $display("FAIL cpu_read.rdata got %h exp 5a", bus.cpu_rdata); end
    checks++; if (bus.owner !== 1'b0) begin errors++; $display("FAIL cpu_read.owner got %b exp 0", bus.owner); end
    bus.cpu_req = 1'b0;
    step(); // cycle 4
    if (bus.dma_ack === 1'b1) dma_seen = 1;
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_read.ack_width got %b exp 0", bus.cpu_ack); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cpu_read.idle_busy got %b exp 0", bus.busy); end
    checks++; if (dma_seen !== 1'b0) begin errors++; $display("FAIL cpu_read.dma_ack got %b exp 0", dma_seen); end
  endtask

  task automatic test_dma_write();
    logic [7:0] rd;
    int lat;
    do_reset();
    drive_dma(1, 1, 8'h22, 8'hC3);
    step(); // cycle 1
    checks++; if (bus.mem_WE !== 1'b1) begin errors++; $display("FAIL dma_write.mem_WE got %b exp 1", bus.mem_WE); end
    checks++; if (bus.mem_addr !== 8'h22) begin errors++; $display("FAIL dma_write.mem_addr got %h exp 22", bus.mem_addr); end
    checks++; if (bus.mem_data_o !== 8'hC3) begin errors++; $display("FAIL dma_write.mem_data_o got %h exp c3", bus.mem_data_o); end
    checks++; if (bus.owner !== 1'b1) begin errors++; $display("FAIL dma_write.owner got %b exp 1", bus.owner); end
    step(); // cycle 2
    checks++; if (bus.mem_WE !== 1'b0) begin errors++; $display("FAIL dma_write.we_width got %b exp 0", bus.mem_WE); end
    step(); // cycle 3
    checks++; if ({bus.dma_ack, bus.cpu_ack} !== 2'b10) begin errors++; $display("FAIL dma_write.acks got %b exp 10", {bus.dma_ack, bus.cpu_ack}); end
    bus.dma_req = 1'b0;
    step();
    checks++; if (bus.mem_data_o !== 8'hC3) begin errors++; $display("FAIL dma_write.data_hold got %h exp c3", bus.mem_data_o); end
    cpu_txn(0, 8'h22, 8'h00, rd, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL dma_write.readback_lat got %0d exp 3", lat); end
    checks++; if (rd !== 8'hC3) begin errors++; $display("FAIL dma_write.readback got %h exp c3", rd); end
  endtask

  task automatic test_simultaneous();
    int ca = -1, da = -1;
    logic [7:0] cr = 8'h00, dr = 8'h00;
    do_reset();
    drive_cpu(1, 0, 8'h30, 8'h00);
    drive_dma(1, 0, 8'h31, 8'h00);
    for (int c = 1; c <= 12; c++) begin
      step();
      if (bus.cpu_ack === 1'b1 && ca < 0) begin ca = c; cr = bus.cpu_rdata; bus.cpu_req = 1'b0; end
      if (bus.dma_ack === 1'b1 && da < 0) begin da = c; dr = bus.dma_rdata; bus.dma_req = 1'b0; end
    end
    checks++; if (ca !== 3) begin errors++; $display("FAIL simul.cpu_ack_cycle got %0d exp 3", ca); end
    checks++; if (da !== 7) begin errors++; $display("FAIL simul.dma_ack_cycle got %0d exp 7", da); end
    checks++; if (cr !== 8'h7A) begin errors++; $display("FAIL simul.cpu_rdata got %h exp 7a", cr); end
    checks++; if (dr !== 8'h7B) begin errors++; $display("FAIL simul.dma_rdata got %h exp 7b", dr); end
    checks++; if (dut.starve_cnt !== 4'd0) begin errors++; $display("FAIL simul.starve_cnt got %0d exp 0", dut.starve_cnt); end
  endtask

  task automatic test_starvation();
    logic [3:0] order = 4'b0000;
    int ackc [4];
    int n = 0;
    for (int i = 0; i < 4; i++) ackc[i] = -1;
    do_reset();
    drive_cpu(1, 0, 8'h01, 8'h00);
    drive_dma(1, 0, 8'h02, 8'h00);
    for (int c = 1; c <= 40; c++) begin
      step();
      if (bus.cpu_ack === 1'b1 && n < 4) begin
        order[n] = 1'b0; ackc[n] = c; n++;
        bus.cpu_addr = bus.cpu_addr + 8'd1;
      end
      if (bus.dma_ack === 1'b1 && n < 4) begin
        order[n] = 1'b1; ackc[n] = c; n++;
        bus.dma_req = 1'b0;
      end
      if (n == 4) break;
    end
    drive_cpu(0, 0, 8'h00, 8'h00);
    drive_dma(0, 0, 8'h00, 8'h00);
    step();
    checks++; if (n !== 4) begin errors++; $display("FAIL starve.ack_count got %0d exp 4", n); end
    checks++; if (order !== 4'b0100) begin errors++; $display("FAIL starve.grant_order got %b exp 0100 (bit0=first)", order); end
    checks++; if (ackc[2] !== 11) begin errors++; $display("FAIL starve.dma_ack_cycle got %0d exp 11", ackc[2]); end
    checks++; if (ackc[3] !== 15) begin errors++; $display("FAIL starve.last_ack_cycle got %0d exp 15", ackc[3]); end
  endtask

  task automatic test_reset_mid_write();
    bit ack_seen = 0;
    bit busy_seen = 0;
    logic [7:0] rd;
    int lat;
    do_reset();
    drive_cpu(1, 1, 8'h40, 8'h99);
    step(); // ST_ACCESS
    checks++; if (bus.mem_WE !== 1'b1) begin errors++; $display("FAIL rst_mid.we_before got %b exp 1", bus.mem_WE); end
    arst = 1'b1;
    bus.cpu_req = 1'b0;
    step();
    checks++; if (bus.mem_WE !== 1'b0) begin errors++; $display("FAIL rst_mid.mem_WE got %b exp 0", bus.mem_WE); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid.busy got %b exp 0", bus.busy); end
    arst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.cpu_ack === 1'b1) ack_seen = 1;
      if (bus.busy === 1'b1) busy_seen = 1;
    end
    checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL rst_mid.stray_ack got %b exp 0", ack_seen); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL rst_mid.stray_busy got %b exp 0", busy_seen); end
    cpu_txn(0, 8'h40, 8'h00, rd, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rst_mid.after_lat got %0d exp 3", lat); end
    checks++; if (rd !== 8'h99) begin errors++; $display("FAIL rst_mid.after_rdata got %h exp 99", rd); end
  endtask

  task automatic test_early_drop();
    bit cpu_seen = 0;
    bit busy_seen = 0;
    do_reset();
    drive_dma(1, 1, 8'h50, 8'h11);
    step(); // DMA in ST_ACCESS
    drive_cpu(1, 0, 8'h60, 8'h00);
    step();
    bus.cpu_req = 1'b0;
    step(); // cycle 3
    checks++; if (bus.dma_ack !== 1'b1) begin errors++; $display("FAIL early_drop.dma_ack got %b exp 1", bus.dma_ack); end
    bus.dma_req = 1'b0;
    step(); // cycle 4
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL early_drop.busy got %b exp 0", bus.busy); end
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.cpu_ack === 1'b1) cpu_seen = 1;
      if (bus.busy === 1'b1) busy_seen = 1;
    end
    checks++; if (cpu_seen !== 1'b0) begin errors++; $display("FAIL early_drop.cpu_ack got %b exp 0", cpu_seen); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL early_drop.regrant got %b exp 0", busy_seen); end
  endtask

  // Transaction-level model: one grant per free slot, fixed 4-cycle occupancy
  task automatic test_random();
    logic [7:0] mram [256];
    int  free_at = 0, g = 0, lost = 0, off;
    bit  have = 0, cp = 0, dp = 0;
    bit  t_dma = 0;
    logic t_we = 0;
    logic [7:0] t_addr = 8'h00, t_wd = 8'h00, t_rd = 8'h00;
    logic [7:0] e_crd = 8'h00, e_drd = 8'h00;
    logic e_busy, e_we, e_cack, e_dack, e_owner;
    logic [7:0] e_addr, e_wdo;
    do_reset();
    for (int i = 0; i < 256; i++) mram[i] = ram[i];
    for (int c = 0; c < 600; c++) begin
      off = have ? (c - g) : 99;
      if (have && off == 3 && !t_we) begin
        if (t_dma) e_drd = t_rd; else e_crd = t_rd;
      end
      e_busy  = have && off >= 1 && off <= 3;
      e_we    = have && off == 1 && t_we;
      e_cack  = have && off == 3 && !t_dma;
      e_dack  = have && off == 3 && t_dma;
      e_owner = have ? t_dma : 1'b0;
      e_addr  = have ? t_addr : 8'h00;
      e_wdo   = have ? t_wd : 8'h00;
      checks++; if (bus.busy !== e_busy) begin errors++; $display("FAIL rand.busy cyc %0d got %b exp %b", c, bus.busy, e_busy); end
      checks++; if (bus.mem_WE !== e_we) begin errors++; $display("FAIL rand.mem_WE cyc %0d got %b exp %b", c, bus.mem_WE, e_we); end
      checks++; if (bus.cpu_ack !== e_cack) begin errors++; $display("FAIL rand.cpu_ack cyc %0d got %b exp %b", c, bus.cpu_ack, e_cack); end
      checks++; if (bus.dma_ack !== e_dack) begin errors++; $display("FAIL rand.dma_ack cyc %0d got %b exp %b", c, bus.dma_ack, e_dack); end
      checks++; if (bus.owner !== e_owner) begin errors++; $display("FAIL rand.owner cyc %0d got %b exp %b", c, bus.owner, e_owner); end
      checks++; if (bus.mem_addr !== e_addr) begin errors++; $display("FAIL rand.mem_addr cyc %0d got %h exp %h", c, bus.mem_addr, e_addr); end
      checks++; if (bus.mem_data_o !== e_wdo) begin errors++; $display("FAIL rand.mem_data_o cyc %0d got %h exp %h", c, bus.mem_data_o, e_wdo); end
      checks++; if (bus.cpu_rdata !== e_crd) begin errors++; $display("FAIL rand.cpu_rdata cyc %0d got %h exp %h", c, bus.cpu_rdata, e_crd); end
      checks++; if (bus.dma_rdata !== e_drd) begin errors++; $display("FAIL rand.dma_rdata cyc %0d got %h exp %h", c, bus.dma_rdata, e_drd); end
      // Requesters: retire on ack, otherwise maybe raise a fresh request
      if (bus.cpu_ack === 1'b1) cp = 0;
      if (bus.dma_ack === 1'b1) dp = 0;
      if (!cp) begin
        if ($urandom_range(2) == 0) begin
          cp = 1;
          drive_cpu(1, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom));
        end else bus.cpu_req = 1'b0;
      end
      if (!dp) begin
        if ($urandom_range(2) == 0) begin
          dp = 1;
          drive_dma(1, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom));
        end else bus.dma_req = 1'b0;
      end
      // Arbitration decision for this cycle, if the memory is free
      if (c >= free_at && (bus.cpu_req || bus.dma_req)) begin
        if (bus.cpu_req && bus.dma_req) begin
          if (lost == SL) begin t_dma = 1; lost = 0; end
          else begin t_dma = 0; lost++; end
        end else if (bus.dma_req) begin
          t_dma = 1; lost = 0;
        end else begin
          t_dma = 0;
        end
        t_we   = t_dma ? bus.dma_we    : bus.cpu_we;
        t_addr = t_dma ? bus.dma_addr  : bus.cpu_addr;
        t_wd   = t_dma ? bus.dma_wdata : bus.cpu_wdata;
        if (t_we) mram[t_addr] = t_wd;
        else      t_rd = mram[t_addr];
        g = c; have = 1; free_at = c + 4;
      end
      step();
    end
    drive_cpu(0, 0, 8'h00, 8'h00);
    drive_dma(0, 0, 8'h00, 8'h00);
  endtask

  initial begin
    drive_cpu(0, 0, 8'h00, 8'h00);
    drive_dma(0, 0, 8'h00, 8'h00);
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid_write();
    test_early_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data memory between the CPU memory stage and a DMA/debug port.
- Sits between the memory interface and the RAM, and owns mem_addr, mem_data_o and mem_WE.
- Each access runs as a fixed 4-phase transaction.
- Arbitration uses fixed CPU priority with a DMA starvation counter that forces a DMA grant.

Parameters:
MEM_ADDR_WIDTH  8  address width of data memory
MEM_DATA_WIDTH  8  data width of data memory
STARVE_LIMIT  4  number of consecutive lost arbitrations after which DMA wins; legal range 1..15

Ports:
clk  in  1  single clock, rising edge
arst  in  1  reset; synchronous, active-high (sampled on rising edge of clk only)
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  MEM_ADDR_WIDTH  CPU address
cpu_wdata  in  MEM_DATA_WIDTH  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  MEM_DATA_WIDTH  CPU read data, valid while cpu_ack=1
dma_req  in  1  DMA request, same rules as cpu_req
dma_we  in  1  DMA write enable
dma_addr  in  MEM_ADDR_WIDTH  DMA address
dma_wdata  in  MEM_DATA_WIDTH  DMA write data
dma_ack  out  1  one-cycle completion pulse
dma_rdata  out  MEM_DATA_WIDTH  DMA read data, valid while dma_ack=1
mem_addr  out  MEM_ADDR_WIDTH  memory address (registered)
mem_data_o  out  MEM_DATA_WIDTH  memory write data (registered)
mem_WE  out  1  memory write enable (registered)
mem_data_i  in  MEM_DATA_WIDTH  memory read data, valid the cycle after mem_addr is presented
busy  out  1  1 in any state other than ST_IDLE
owner  out  1  0=CPU, 1=DMA; last granted requester

Behaviour:
Reset values (arst=1 at a clk edge):
- All outputs 0.
- state=ST_IDLE, starve_cnt=0.
- A reset mid-transaction aborts it: no ack is issued, and mem_WE is 0 from the next cycle.

States and transitions (ST_IDLE, ST_ACCESS, ST_RESP, ST_DONE):
- ST_IDLE:
  - No request: stay in ST_IDLE.
  - Otherwise pick a winner, register mem_addr, mem_data_o=wdata, mem_WE=we and owner from the winner, then go to ST_ACCESS.
- ST_ACCESS: memory sees the address and write enable; mem_WE <= 0; go to ST_RESP.
- ST_RESP:
  - If the access is a read, rdata of the owner <= mem_data_i; otherwise rdata holds its previous value.
  - ack of the owner <= 1; go to ST_DONE.
- ST_DONE: the ack is high for exactly this cycle; ack <= 0; go to ST_IDLE.

Timing and handshake:
- Latency: req sampled high in ST_IDLE at cycle N -> ack high in cycle N+3.
- Minimum spacing between grants is 4 cycles.
- Requester holds req/we/addr/wdata stable from assertion until it samples ack=1.
- Requester deasserts req on that same edge, so the request is not re-granted.
- A req that drops before its grant is ignored; no error is raised.
- The non-granted requester waits; its inputs are not sampled until it is granted.

Arbitration (evaluated in ST_IDLE only):
- Only cpu_req: CPU wins.
- Only dma_req: DMA wins; starve_cnt <= 0.
- Both requesting, starve_cnt < STARVE_LIMIT: CPU wins; starve_cnt <= starve_cnt+1.
- Both requesting, starve_cnt == STARVE_LIMIT: DMA wins; starve_cnt <= 0.
- Whenever DMA wins, starve_cnt clears.
- starve_cnt never exceeds STARVE_LIMIT (saturating); its width is 4 bits.

Other rules:
- rdata registers are not cleared by later writes.
- mem_data_o holds its last value when idle.
- mem_WE is high for exactly one cycle (the ST_ACCESS cycle) per write.

Test Plan:
- CPU read alone: mem holds 0x5A at 0x10; cpu_req=1, we=0, addr=0x10 at cycle 0 -> mem_addr=0x10 at cycle 1; cpu_ack=1 with cpu_rdata=0x5A at cycle 3; dma_ack stays 0; owner=0.
- DMA write alone: dma addr=0x22, wdata=0xC3 -> mem_WE=1 only in cycle 1 with mem_addr=0x22, mem_data_o=0xC3; dma_ack at cycle 3; read-back via CPU returns 0xC3.
- Simultaneous requests, starve_cnt=0: CPU is served first (cpu_ack at cycle 3); DMA is granted at cycle 4 with dma_ack at cycle 7; starve_cnt is 0 after the DMA grant.
- Starvation, STARVE_LIMIT=2: CPU re-requests back-to-back while dma_req is held -> grants go CPU, CPU, DMA, CPU; dma_ack after exactly the 2nd CPU transaction.
- Reset mid-write: assert arst during the ST_ACCESS cycle of a CPU write -> next cycle mem_WE=0, busy=0, no cpu_ack ever; a new request after reset completes normally.
- Early req drop: cpu_req pulses for 1 cycle while the DMA transaction is in flight -> no CPU grant, cpu_ack stays 0, and the arbiter returns to ST_IDLE with busy=0.
